// File: rtl/decoder_32_reg.sv
// decoder_32_reg
//
// Registered 5-to-32 one-hot decoder with active-high enable. Produces the
// per-register write strobes for a 32-entry register file: the register index
// comes in on `select` and the matching strobe line goes out on `out`, one
// clock later.
//
// Ports:
//   clock    in   1   system clock, all state updates on its rising edge
//   reset_n  in   1   asynchronous active-low reset, clears `out`
//   select   in   5   binary index of the line to assert (0..31)
//   enable   in   1   active-high decode enable; 0 forces all lines low
//   out      out  32  registered one-hot decode (or all zeros)
//
// out[0] corresponds to select == 0 and out[31] to select == 31.

module decoder_32_reg (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  select,
    input  logic        enable,
    output logic [31:0] out
);

    // Predecoded select fields. The enable gate sits on the 2-to-4 stage so
    // that every term of the final AND carries it: with enable low all upper
    // lines are 0, and an unknown select cannot reach the register.
    logic [3:0]  hi_dec;
    logic [7:0]  lo_dec;
    logic [31:0] out_d;
    logic [31:0] out_q;

    // 2-to-4 predecoder on select[4:3], gated by enable.
    always_comb begin
        hi_dec = 4'b0000;
        for (int h = 0; h < 4; h++) begin
            hi_dec[h] = enable && (select[4:3] == 2'(h));
        end
    end

    // 3-to-8 predecoder on select[2:0].
    always_comb begin
        lo_dec = 8'b0000_0000;
        for (int l = 0; l < 8; l++) begin
            lo_dec[l] = (select[2:0] == 3'(l));
        end
    end

    // Line 8*h + l is asserted when both predecoders select it.
    always_comb begin
        out_d = 32'h0000_0000;
        for (int h = 0; h < 4; h++) begin
            for (int l = 0; l < 8; l++) begin
                out_d[8*h + l] = hi_dec[h] & lo_dec[l];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= 32'h0000_0000;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_decoder_32_reg.sv
// Self-checking bench for decoder_32_reg. The stimulus process drives inputs
// on the falling edge and pushes the expected registered value into a queue;
// a separate monitor pops one entry after every rising edge and compares it
// against `out`, also checking the one-hot invariant.

module tb_decoder_32_reg;

    logic        clock;
    logic        reset_n;
    logic [4:0]  select;
    logic        enable;
    logic [31:0] out;

    int unsigned n_vec;
    int unsigned n_err;

    logic [31:0] sb[$];

    decoder_32_reg dut (
        .clock   (clock),
        .reset_n (reset_n),
        .select  (select),
        .enable  (enable),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // One stimulus cycle: drive inputs mid-cycle, queue the value the next
    // rising edge must load.
    task automatic step(input logic rn, input logic en, input logic [4:0] sel,
                        input logic [31:0] exp);
        @(negedge clock);
        reset_n = rn;
        enable  = en;
        select  = sel;
        sb.push_back(exp);
    endtask

    // Monitor: output is valid every cycle, sampled just after the edge.
    initial begin
        logic [31:0] exp;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("scoreboard", out, exp);
                check("onehot", {31'd0, ($countones(out) <= 1)}, 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: out=%h expected=finish", out);
        $fatal(1, "timeout");
    end

    initial begin
        logic       en;
        logic [4:0] sel;

        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        enable  = 1'b1;
        select  = 5'd6;
        #1;
        check("reset_async", out, 32'h0000_0000);

        // Reset held with enable=1, select=6: clock edges have no effect.
        repeat (3) step(1'b0, 1'b1, 5'd6, 32'h0000_0000);
        // Release: first edge loads decode of 6.
        step(1'b1, 1'b1, 5'd6, 32'h0000_0040);

        // Disabled decode, including unknown select.
        step(1'b1, 1'b0, 5'd6,    32'h0000_0000);
        step(1'b1, 1'b0, 5'd31,   32'h0000_0000);
        step(1'b1, 1'b0, 5'bxxxxx, 32'h0000_0000);

        // Exhaustive sweep on consecutive edges.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 5'(i), 32'h1 << i);
        end
        step(1'b1, 1'b1, 5'd0,  32'h0000_0001);
        step(1'b1, 1'b1, 5'd31, 32'h8000_0000);

        // Enable gating mid-stream with select held at 17.
        step(1'b1, 1'b1, 5'd17, 32'h0002_0000);
        step(1'b1, 1'b0, 5'd17, 32'h0000_0000);
        step(1'b1, 1'b1, 5'd17, 32'h0002_0000);

        // Asynchronous reset pulse between edges.
        step(1'b1, 1'b1, 5'd12, 32'h0000_1000);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_mid_cycle", out, 32'h0000_0000);
        reset_n = 1'b1;
        step(1'b1, 1'b1, 5'd12, 32'h0000_1000);

        // Random traffic against a behavioural reference.
        for (int i = 0; i < 1000; i++) begin
            en  = 1'($urandom_range(0, 3) != 0);
            sel = 5'($urandom_range(0, 31));
            step(1'b1, en, sel, en ? (32'h1 << sel) : 32'h0000_0000);
        end

        // Drain: the monitor must have consumed every queued expectation.
        @(posedge clock);
        #3;
        check("drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
